seg7_scan_driver: RTL and testbench

- Display back-end that sits directly downstream of the game FSM.
- Consumes the four 4-bit digit codes (dig0..dig3) plus per-digit decimal-point and blink masks, and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Digits are snapshotted once per scan frame so that no displayed frame mixes old and new values.

---
 rtl/seg7_scan_driver.sv | 82 ++++++++
 tb/tb_seg7_scan_driver.sv | 102 ++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: frame-snapshotted, blinkable 4-digit common-anode seven-segment scanner
module seg7_scan_driver #(
  parameter int SCAN_TICKS  = 100000,
  parameter int BLINK_TICKS = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] dp_mask,
  input  logic [3:0] blink_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int SW = $clog2(SCAN_TICKS);
  localparam int BW = $clog2(BLINK_TICKS);
  logic [SW-1:0] scan_cnt, scan_cnt_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic [1:0] idx, idx_n;
  logic blink_phase, blink_phase_n, scan_wrap, blink_wrap, frame, off;
  logic [3:0][3:0] sh_dig, sh_dig_n;
  logic [3:0] sh_dp, sh_dp_n, sh_blink, sh_blink_n, code;
  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      4'd11:   decode = 7'b0111111;
      default: decode = 7'b1111111;
    endcase
  endfunction
  // Outputs are built from next-state values so anode and segment data switch together
  always_comb begin
    scan_wrap     = scan_cnt == SW'(SCAN_TICKS - 1);
    blink_wrap    = blink_cnt == BW'(BLINK_TICKS - 1);
    scan_cnt_n    = scan_wrap ? '0 : scan_cnt + 1'b1;
    blink_cnt_n   = blink_wrap ? '0 : blink_cnt + 1'b1;
    blink_phase_n = blink_phase ^ blink_wrap;
    idx_n         = scan_wrap ? idx + 2'd1 : idx;
    frame         = scan_wrap && idx == 2'd3;
    sh_dig_n      = frame ? {dig3, dig2, dig1, dig0} : sh_dig;
    sh_dp_n       = frame ? dp_mask : sh_dp;
    sh_blink_n    = frame ? blink_mask : sh_blink;
    code          = sh_dig_n[idx_n];
    off           = blink_phase_n & sh_blink_n[idx_n];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      idx         <= '0;
      blink_phase <= 1'b0;
      sh_dig      <= {4{4'd10}};
      sh_dp       <= '0;
      sh_blink    <= '0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
    end else begin
      scan_cnt    <= scan_cnt_n;
      blink_cnt   <= blink_cnt_n;
      idx         <= idx_n;
      blink_phase <= blink_phase_n;
      sh_dig      <= sh_dig_n;
      sh_dp       <= sh_dp_n;
      sh_blink    <= sh_blink_n;
      an          <= ~(4'b0001 << idx_n);
      seg         <= off ? 7'b1111111 : decode(code);
      dp          <= off | ~sh_dp_n[idx_n];
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, decode, snapshotting, blink and reset
module tb_seg7_scan_driver;
  localparam int ST = 4;
  localparam int BT = 20;
  logic clk = 0, rst = 1;
  logic [3:0] dig0 = 0, dig1 = 0, dig2 = 0, dig3 = 0, dp_mask = 0, blink_mask = 0;
  logic [6:0] seg;
  logic dp;
  logic [3:0] an;
  int total = 0, bad = 0, k = 0;
  logic [3:0] sd [4];
  logic [3:0] sdp, sbl;
  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b1111111, 7'b0111111,
                           7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
  seg7_scan_driver #(.SCAN_TICKS(ST), .BLINK_TICKS(BT)) dut (
    .clk(clk), .rst(rst), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dp_mask(dp_mask), .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
    end
  endtask
  task automatic dark_check();
    chk("rst_an", {4'b0, an}, 8'h0f);
    chk("rst_seg", {1'b0, seg}, 8'h7f);
    chk("rst_dp", {7'b0, dp}, 8'h01);
  endtask
  task automatic restart();
    k = 0;
    sd = '{4'd10, 4'd10, 4'd10, 4'd10};
    sdp = 0;
    sbl = 0;
  endtask
  task automatic tick();
    int i;
    logic ph, off, e_dp;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    @(posedge clk);
    k++;
    if (k % 16 == 0) begin
      sd = '{dig0, dig1, dig2, dig3};
      sdp = dp_mask;
      sbl = blink_mask;
    end
    #1;
    i = (k / ST) % 4;
    ph = ((k / BT) % 2) == 1;
    off = ph & sbl[i];
    e_an = ~(4'b0001 << i);
    e_seg = off ? 7'b1111111 : dec[sd[i]];
    e_dp = off | ~sdp[i];
    chk("an", {4'b0, an}, {4'b0, e_an});
    chk("seg", {1'b0, seg}, {1'b0, e_seg});
    chk("dp", {7'b0, dp}, {7'b0, e_dp});
  endtask
  task automatic frames(input int n);
    repeat (16 * n) tick();
  endtask
  task automatic set_digs(input logic [3:0] a, b, c, d);
    dig0 = a; dig1 = b; dig2 = c; dig3 = d;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1 dark_check();
    set_digs(0, 1, 2, 3);
    @(negedge clk) rst = 1;
    restart();
    frames(2);
    set_digs(4, 5, 6, 7);
    frames(2);
    set_digs(8, 9, 8, 9);
    frames(2);
    set_digs(8, 11, 10, 15);
    dp_mask = 4'b0100;
    frames(2);
    dp_mask = 0;
    set_digs(5, 1, 2, 3);
    frames(2);
    while (k % 16 != 8) tick();
    dig0 = 7;
    frames(2);
    set_digs(8, 8, 8, 8);
    blink_mask = 4'b0001;
    frames(4);
    while (k % 16 != 9) tick();
    rst = 0;
    #1 dark_check();
    @(negedge clk) rst = 1;
    restart();
    frames(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
